mem_arbiter: RTL
================

# mem_arbiter

Two-master, single-slave arbiter sharing one unified memory port between instruction fetch (IF) and load/store (LS) in the multi-cycle core. Sequences each access through a three-state FSM: round-robin grant, forward and latch the request, wait for memory ready, return data. A watchdog aborts stalled accesses. Sits between the fetch/LSU front ends and the memory, replacing the separate inst/data memory paths.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, max BUSY cycles without mem_ready before abort (≥2)
- clk  in  1  clock, all flops rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request (read only)
- if_addr  in  AW  fetch address
- if_gnt  out  1  IF owns the memory (BUSY/RESP)
- if_done  out  1  one-cycle completion pulse
- if_err  out  1  timeout flag, valid with if_done
- if_rdata  out  DW  fetched word, valid with if_done
- ls_req  in  1  load/store request
- ls_we  in  1  1 = store
- ls_addr  in  AW  data address
- ls_wdata  in  DW  store data
- ls_type  in  3  access size/sign code (shared encoding)
- ls_gnt, ls_done, ls_err, ls_rdata  out  1/1/1/DW  as IF counterparts
- mem_req  out  1  access active
- mem_we  out  1  write enable
- mem_addr  out  AW  latched address
- mem_wdata  out  DW  latched store data
- mem_type  out  3  latched type (IF forces word-read code)
- mem_rdata  in  DW  read data, valid when mem_ready
- mem_ready  in  1  access complete this cycle

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: sample if_req/ls_req. One requesting → grant it. Both → grant the one not granted last (last_owner). None → stay.
- Grant edge (IDLE→BUSY): latch owner, addr, wdata, we, type into mem_* registers; set owner's gnt; clear watchdog; update last_owner.
- BUSY: mem_req=1. mem_ready=1 → capture mem_rdata (0 for writes), go RESP, err=0. Watchdog = TIMEOUT-1 with mem_ready=0 → go RESP, err=1, rdata=0.
- RESP: owner's done=1 (one cycle), err/rdata driven; mem_req=0; next IDLE, gnt cleared.
- Non-owner outputs always 0. Requests ignored outside IDLE.
- Requester rule: once granted, inputs may change freely (latched). Requester drops req in the cycle after done unless issuing a new access; any req seen in IDLE is a new access.
- Watchdog: $clog2(TIMEOUT) bits, counts BUSY cycles; cleared on grant; saturates never (abort first).

## Timing
- All outputs registered. Reset (async, rst=0): state IDLE, all outputs 0, counter 0, last_owner=IF (LS wins first tie).
- Zero-wait memory: req in cycle 0 (IDLE) → gnt, mem_req in cycle 1 → done cycle 2 → IDLE cycle 3. Min 3 cycles/access; N wait states add N.
- Timeout: mem_req high exactly TIMEOUT cycles, done+err next cycle.
- mem_ready in the same cycle the watchdog expires: ready wins, err=0.
- mem_ready outside BUSY ignored.
- Reset mid-access: mem_req drops asynchronously; no done issued; requester reissues after reset.

## Structure
- Package mem_arb_pkg: arb_state_t enum {ARB_IDLE, ARB_BUSY, ARB_RESP}; owner_t enum {OWN_IF, OWN_LS}; mem_type codes (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU), shared with data_mem and controller.
- One sub-module rr_pick2: combinational 2-way round-robin picker (req[1:0], last_owner → grant owner, valid).

## Test plan
- Single IF read, mem_ready tied 1, if_addr=0x100, mem_rdata=0xDEADBEEF → if_gnt cycle 1, if_done+rdata=0xDEADBEEF cycle 2, idle cycle 3.
- Simultaneous if_req/ls_req held after reset → LS, IF, LS, IF grant order; no port granted twice in a row.
- LS store ls_addr=0x20, wdata=0xA5A5A5A5, type=MEM_B, 2 wait states → mem_we=1, mem_* stable 3 cycles, ls_done with rdata=0, err=0.
- mem_ready held 0, TIMEOUT=16 → mem_req high 16 cycles, if_done+if_err=1, rdata=0; next access succeeds normally.
- Ready coinciding with watchdog expiry (ready on 16th BUSY cycle) → done, err=0, data returned.
- rst low in BUSY → mem_req/gnt 0 immediately, no done; after release LS wins first tie.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared arbiter states, owner ids and memory access type codes
package mem_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;
  localparam logic [2:0] MEM_B  = 3'd0;
  localparam logic [2:0] MEM_H  = 3'd1;
  localparam logic [2:0] MEM_W  = 3'd2;
  localparam logic [2:0] MEM_BU = 3'd4;
  localparam logic [2:0] MEM_HU = 3'd5;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin picker, a tie goes to the port not granted last
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  output owner_t     owner,
  output logic       valid
);
  // req[0] is IF, req[1] is LS
  always_comb begin
    owner = &req ? (last_owner == OWN_IF ? OWN_LS : OWN_IF) : (req[1] ? OWN_LS : OWN_IF);
    valid = |req;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin IF/LS arbiter for one shared memory port with a stall watchdog
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_done,
  output logic          if_err,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  input  logic [2:0]    ls_type,
  output logic          ls_gnt,
  output logic          ls_done,
  output logic          ls_err,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_type,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);
  localparam int WW = $clog2(TIMEOUT);
  arb_state_t    state_q, state_d;
  owner_t        owner_q, owner_d, last_q, last_d, pick;
  logic          pick_valid;
  logic [WW-1:0] wd_q, wd_d;
  logic          if_gnt_q, if_gnt_d, ls_gnt_q, ls_gnt_d;
  logic          if_done_q, if_done_d, ls_done_q, ls_done_d;
  logic          if_err_q, if_err_d, ls_err_q, ls_err_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]    mem_type_q, mem_type_d;
  logic          done_now;
  logic [DW-1:0] rdata_now;

  rr_pick2 u_pick (
    .req       ({ls_req, if_req}),
    .last_owner(last_q),
    .owner     (pick),
    .valid     (pick_valid)
  );

  // next state: grant and latch in IDLE, watch memory in BUSY, one response cycle in RESP
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    wd_d        = wd_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_type_d  = mem_type_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    if_gnt_d    = 1'b0;
    ls_gnt_d    = 1'b0;
    if_done_d   = 1'b0;
    ls_done_d   = 1'b0;
    if_err_d    = 1'b0;
    ls_err_d    = 1'b0;
    if_rdata_d  = '0;
    ls_rdata_d  = '0;
    done_now    = mem_ready || wd_q == WW'(TIMEOUT - 1);
    rdata_now   = mem_ready && !mem_we_q ? mem_rdata : '0;
    case (state_q)
      ARB_IDLE: if (pick_valid) begin
        state_d     = ARB_BUSY;
        owner_d     = pick;
        last_d      = pick;
        wd_d        = '0;
        mem_addr_d  = pick == OWN_LS ? ls_addr : if_addr;
        mem_wdata_d = pick == OWN_LS ? ls_wdata : '0;
        mem_type_d  = pick == OWN_LS ? ls_type : MEM_W;
        mem_we_d    = pick == OWN_LS && ls_we;
        mem_req_d   = 1'b1;
        if_gnt_d    = pick == OWN_IF;
        ls_gnt_d    = pick == OWN_LS;
      end
      ARB_BUSY: begin
        if_gnt_d = owner_q == OWN_IF;
        ls_gnt_d = owner_q == OWN_LS;
        if (done_now) begin
          state_d    = ARB_RESP;
          if_done_d  = owner_q == OWN_IF;
          ls_done_d  = owner_q == OWN_LS;
          if_err_d   = owner_q == OWN_IF && !mem_ready;
          ls_err_d   = owner_q == OWN_LS && !mem_ready;
          if_rdata_d = owner_q == OWN_IF ? rdata_now : '0;
          ls_rdata_d = owner_q == OWN_LS ? rdata_now : '0;
        end else begin
          wd_d      = wd_q + 1'b1;
          mem_req_d = 1'b1;
          mem_we_d  = mem_we_q;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // state and registered outputs; reset leaves IF as last owner so LS wins the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IF;
      last_q      <= OWN_IF;
      wd_q        <= '0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      if_err_q    <= 1'b0;
      ls_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_type_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      wd_q        <= wd_d;
      if_gnt_q    <= if_gnt_d;
      ls_gnt_q    <= ls_gnt_d;
      if_done_q   <= if_done_d;
      ls_done_q   <= ls_done_d;
      if_err_q    <= if_err_d;
      ls_err_q    <= ls_err_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_type_q  <= mem_type_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign ls_gnt    = ls_gnt_q;
  assign if_done   = if_done_q;
  assign ls_done   = ls_done_q;
  assign if_err    = if_err_q;
  assign ls_err    = ls_err_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_type  = mem_type_q;
endmodule
